// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - Y86 icode/register constants and pipeline-control FSM types
package pipe_ctrl_pkg;

    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_t;

    // Y86 instruction codes
    localparam byte_t IHALT   = 8'h00;
    localparam byte_t INOP    = 8'h01;
    localparam byte_t IRRMOVL = 8'h02;
    localparam byte_t IIRMOVL = 8'h03;
    localparam byte_t IRMMOVL = 8'h04;
    localparam byte_t IMRMOVL = 8'h05;
    localparam byte_t IOPL    = 8'h06;
    localparam byte_t IJXX    = 8'h07;
    localparam byte_t ICALL   = 8'h08;
    localparam byte_t IRET    = 8'h09;
    localparam byte_t IPUSHL  = 8'h0A;
    localparam byte_t IPOPL   = 8'h0B;

    // Register id meaning "no register"
    localparam byte_t RNONE   = 8'h0F;

    typedef enum logic [1:0] {
        PCTL_RUN       = 2'd0,
        PCTL_RET_DRAIN = 2'd1,
        PCTL_HALTED    = 2'd2
    } pctl_state_e;

    // True for instructions whose result only appears after the memory stage
    function automatic logic loads_reg(input byte_t icode);
        return (icode == IMRMOVL) || (icode == IPOPL);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage observation fields and stall/bubble controls between datapath and pipe_ctrl
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    byte_t d_icode;
    byte_t d_srcA;
    byte_t d_srcB;
    byte_t e_icode;
    byte_t e_dstM;
    logic  e_cnd;
    logic  m_exc;
    logic  w_halt;

    logic  f_stall;
    logic  d_stall;
    logic  d_bubble;
    logic  e_bubble;
    logic  m_bubble;
    logic  w_stall;
    logic  ret_busy;
    logic  halted;

    // Datapath side: supplies stage fields, consumes controls
    modport master (
        output d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_exc, w_halt,
        input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, ret_busy, halted
    );

    // Control side: observes stage fields, drives controls
    modport slave (
        input  d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_exc, w_halt,
        output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, ret_busy, halted
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - saturating event counter with increment and freeze inputs
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         freeze,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count qualified events, sticking at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !freeze && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register, cleared by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86 5-stage pipeline control: load-use, mispredict, ret drain, halt freeze; optional PIPE_CTRL_PERF_EN counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RET_BUBBLES = 3
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave io
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_mp,
    output logic [PERF_W-1:0] perf_ret
`endif
);

    // The cycle ret enters decode is the first hold cycle, so the counter covers the rest
    localparam logic [2:0] RET_LOAD = 3'(RET_BUBBLES - 1);

    pctl_state_e state_q;
    pctl_state_e state_d;
    logic [2:0]  ret_cnt_q;
    logic [2:0]  ret_cnt_d;

    logic lu;
    logic mp;
    logic rt;

    assign lu = loads_reg(io.e_icode) && (io.e_dstM != RNONE) &&
                ((io.e_dstM == io.d_srcA) || (io.e_dstM == io.d_srcB));
    assign mp = (io.e_icode == IJXX) && !io.e_cnd;
    assign rt = (io.d_icode == IRET);

    // State and drain counter; reset aborts any drain or halt immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= PCTL_RUN;
            ret_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // Next state and stage controls; mispredict beats load-use beats ret in RUN
    always_comb begin
        state_d     = state_q;
        ret_cnt_d   = ret_cnt_q;
        io.f_stall  = 1'b0;
        io.d_stall  = 1'b0;
        io.d_bubble = 1'b0;
        io.e_bubble = 1'b0;
        io.m_bubble = 1'b0;
        io.w_stall  = 1'b0;
        io.ret_busy = 1'b0;
        io.halted   = 1'b0;

        case (state_q)
            PCTL_RUN: begin
                if (mp) begin
                    // Wrong-path instructions in decode and execute are squashed,
                    // including a ret sitting in decode
                    io.d_bubble = 1'b1;
                    io.e_bubble = 1'b1;
                end else if (lu) begin
                    io.f_stall  = 1'b1;
                    io.d_stall  = 1'b1;
                    io.e_bubble = 1'b1;
                end else if (rt) begin
                    io.f_stall  = 1'b1;
                    io.d_bubble = 1'b1;
                    if (RET_BUBBLES > 1) begin
                        ret_cnt_d = RET_LOAD;
                        state_d   = PCTL_RET_DRAIN;
                    end
                end
                io.m_bubble = io.m_exc;
            end
            PCTL_RET_DRAIN: begin
                // Hazard inputs are not looked at: only bubbles follow the ret
                io.f_stall  = 1'b1;
                io.d_bubble = 1'b1;
                io.ret_busy = 1'b1;
                io.m_bubble = io.m_exc;
                ret_cnt_d   = ret_cnt_q - 3'd1;
                if (ret_cnt_q == 3'd1) begin
                    state_d = PCTL_RUN;
                end
            end
            PCTL_HALTED: begin
                io.f_stall  = 1'b1;
                io.d_stall  = 1'b1;
                io.e_bubble = 1'b1;
                io.m_bubble = 1'b1;
                io.w_stall  = 1'b1;
                io.halted   = 1'b1;
            end
            default: begin
                state_d   = PCTL_RUN;
                ret_cnt_d = 3'd0;
            end
        endcase

        if (io.w_halt) begin
            state_d = PCTL_HALTED;
        end

        // While reset is held every control is quiet regardless of inputs
        if (!rst) begin
            io.f_stall  = 1'b0;
            io.d_stall  = 1'b0;
            io.d_bubble = 1'b0;
            io.e_bubble = 1'b0;
            io.m_bubble = 1'b0;
            io.w_stall  = 1'b0;
            io.ret_busy = 1'b0;
            io.halted   = 1'b0;
        end
    end

    // Holding and flushing IF/ID in the same cycle would be contradictory
    a_no_stall_and_bubble: assert property (@(posedge clk) disable iff (!rst)
        !(io.d_stall && io.d_bubble));

`ifdef PIPE_CTRL_PERF_EN
    logic lu_act;
    logic mp_act;
    logic ret_act;
    logic frozen;

    assign frozen  = (state_q == PCTL_HALTED);
    assign mp_act  = (state_q == PCTL_RUN) && mp;
    assign lu_act  = (state_q == PCTL_RUN) && !mp && lu;
    assign ret_act = (state_q == PCTL_RET_DRAIN) || ((state_q == PCTL_RUN) && !mp && !lu && rt);

    pipe_perf_cnt #(.W(PERF_W)) u_perf_lu (
        .clk(clk), .rst(rst), .inc(lu_act), .freeze(frozen), .cnt(perf_lu)
    );
    pipe_perf_cnt #(.W(PERF_W)) u_perf_mp (
        .clk(clk), .rst(rst), .inc(mp_act), .freeze(frozen), .cnt(perf_mp)
    );
    pipe_perf_cnt #(.W(PERF_W)) u_perf_ret (
        .clk(clk), .rst(rst), .inc(ret_act), .freeze(frozen), .cnt(perf_ret)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int RET_BUBBLES = 3;

    logic clk;
    logic rst;

    pipe_ctrl_if bif();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_lu;
    logic [31:0] perf_mp;
    logic [31:0] perf_ret;
    int unsigned m_plu, m_pmp, m_pret;
`endif

    pipe_ctrl #(.RET_BUBBLES(RET_BUBBLES)) dut (
        .clk(clk),
        .rst(rst),
        .io(bif)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_lu(perf_lu),
        .perf_mp(perf_mp),
        .perf_ret(perf_ret)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remaining ret-hold cycles and a sticky halt flag
    int         m_hold, n_hold;
    bit         m_halted, n_halted;
    bit         inc_lu, inc_mp, inc_ret;
    logic [7:0] exp_vec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, ret_busy, halted}
    function automatic logic [7:0] obs_vec();
        return {bif.f_stall, bif.d_stall, bif.d_bubble, bif.e_bubble,
                bif.m_bubble, bif.w_stall, bif.ret_busy, bif.halted};
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_eval();
        bit lu, mp, rt;
        lu = ((bif.e_icode == IMRMOVL) || (bif.e_icode == IPOPL)) && (bif.e_dstM != RNONE) &&
             ((bif.e_dstM == bif.d_srcA) || (bif.e_dstM == bif.d_srcB));
        mp = (bif.e_icode == IJXX) && !bif.e_cnd;
        rt = (bif.d_icode == IRET);
        exp_vec  = 8'h00;
        inc_lu   = 1'b0;
        inc_mp   = 1'b0;
        inc_ret  = 1'b0;
        if (!rst) begin
            m_hold   = 0;
            m_halted = 1'b0;
            n_hold   = 0;
            n_halted = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
            m_plu = 0; m_pmp = 0; m_pret = 0;
`endif
        end else begin
            n_hold   = m_hold;
            n_halted = m_halted;
            if (m_halted) begin
                exp_vec = 8'b1101_1101;
            end else if (m_hold > 0) begin
                exp_vec = 8'b1010_0010;
                n_hold  = m_hold - 1;
                inc_ret = 1'b1;
            end else if (mp) begin
                exp_vec = 8'b0011_0000;
                inc_mp  = 1'b1;
            end else if (lu) begin
                exp_vec = 8'b1101_0000;
                inc_lu  = 1'b1;
            end else if (rt) begin
                exp_vec = 8'b1010_0000;
                n_hold  = RET_BUBBLES - 1;
                inc_ret = 1'b1;
            end
            if (!m_halted && bif.m_exc) exp_vec[3] = 1'b1;
            if (bif.w_halt) n_halted = 1'b1;
        end
    endtask

    // One clock: sample at the falling edge, advance the model at the rising edge
    task automatic cycle(input string tag, input bit use_c, input logic [7:0] c);
        @(negedge clk);
        model_eval();
        check8(tag, obs_vec(), use_c ? c : exp_vec);
`ifdef PIPE_CTRL_PERF_EN
        check32({tag, "_perf_lu"}, perf_lu, m_plu);
        check32({tag, "_perf_mp"}, perf_mp, m_pmp);
        check32({tag, "_perf_ret"}, perf_ret, m_pret);
`endif
        @(posedge clk);
        m_hold   = n_hold;
        m_halted = n_halted;
`ifdef PIPE_CTRL_PERF_EN
        m_plu  += inc_lu;
        m_pmp  += inc_mp;
        m_pret += inc_ret;
`endif
        #1;
    endtask

    task automatic quiet();
        bif.d_icode = INOP;
        bif.d_srcA  = RNONE;
        bif.d_srcB  = RNONE;
        bif.e_icode = INOP;
        bif.e_dstM  = RNONE;
        bif.e_cnd   = 1'b0;
        bif.m_exc   = 1'b0;
        bif.w_halt  = 1'b0;
    endtask

    function automatic byte_t rand_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? RNONE : byte_t'(r);
    endfunction

    task automatic rand_inputs(input bit allow_rst);
        case ($urandom_range(0, 4))
            0: bif.e_icode = IMRMOVL;
            1: bif.e_icode = IPOPL;
            2: bif.e_icode = IJXX;
            3: bif.e_icode = IOPL;
            default: bif.e_icode = byte_t'($urandom_range(0, 11));
        endcase
        bif.d_icode = ($urandom_range(0, 3) == 0) ? IRET : byte_t'($urandom_range(0, 11));
        bif.d_srcA  = rand_reg();
        bif.d_srcB  = rand_reg();
        bif.e_dstM  = rand_reg();
        bif.e_cnd   = 1'($urandom_range(0, 1));
        bif.m_exc   = ($urandom_range(0, 7) == 0);
        bif.w_halt  = ($urandom_range(0, 79) == 0);
        rst         = allow_rst ? ($urandom_range(0, 59) != 0) : 1'b1;
    endtask

    initial begin
        m_hold = 0; m_halted = 1'b0; n_hold = 0; n_halted = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
        m_plu = 0; m_pmp = 0; m_pret = 0;
`endif
        // Reset held with hazards present keeps every control low
        rst = 1'b0;
        quiet();
        bif.w_halt  = 1'b1;
        bif.d_icode = IRET;
        #1;
        cycle("reset_hold", 1'b1, 8'h00);
        cycle("reset_hold2", 1'b1, 8'h00);
        rst = 1'b1;
        quiet();
        cycle("run_idle", 1'b1, 8'h00);

        // Load-use
        bif.e_icode = IMRMOVL; bif.e_dstM = 8'd3; bif.d_srcB = 8'd3;
        cycle("lu_stall", 1'b1, 8'hD0);
        bif.e_dstM = RNONE;
        cycle("lu_rnone", 1'b1, 8'h00);
        quiet();
        bif.e_icode = IPOPL; bif.e_dstM = 8'd5; bif.d_srcA = 8'd5;
        cycle("lu_popl_srcA", 1'b1, 8'hD0);

        // Ret drain
        quiet();
        bif.d_icode = IRET;
        cycle("ret_c1", 1'b1, 8'hA0);
        bif.d_icode = INOP;
        cycle("ret_c2", 1'b1, 8'hA2);
        cycle("ret_c3", 1'b1, 8'hA2);
        cycle("ret_c4_run", 1'b1, 8'h00);

        // Mispredict squashes a ret in decode
        bif.e_icode = IJXX; bif.e_cnd = 1'b0; bif.d_icode = IRET;
        cycle("mp_flush", 1'b1, 8'h30);
        quiet();
        cycle("mp_no_drain", 1'b1, 8'h00);
        bif.e_icode = IJXX; bif.e_cnd = 1'b1;
        cycle("jxx_taken", 1'b1, 8'h00);

        // Ret waits behind load-use
        quiet();
        bif.e_icode = IMRMOVL; bif.e_dstM = 8'd2; bif.d_srcA = 8'd2; bif.d_icode = IRET;
        cycle("ret_lu", 1'b1, 8'hD0);
        bif.e_icode = INOP; bif.e_dstM = RNONE;
        cycle("ret_after_lu", 1'b1, 8'hA0);
        bif.d_icode = INOP; bif.d_srcA = RNONE;
        cycle("ret_lu_d2", 1'b1, 8'hA2);
        cycle("ret_lu_d3", 1'b1, 8'hA2);
        cycle("ret_lu_run", 1'b1, 8'h00);

        // Memory exception adds an EX/MEM bubble on top of other controls
        bif.m_exc = 1'b1;
        cycle("mexc_run", 1'b1, 8'h08);
        bif.m_exc = 1'b0; bif.d_icode = IRET;
        cycle("mexc_ret_c1", 1'b1, 8'hA0);
        bif.d_icode = INOP; bif.m_exc = 1'b1;
        cycle("mexc_drain", 1'b1, 8'hAA);
        bif.m_exc = 1'b0;
        cycle("mexc_drain3", 1'b1, 8'hA2);
        cycle("mexc_run2", 1'b1, 8'h00);

        // Halt during drain, with fresh counters
        rst = 1'b0;
        cycle("reset2", 1'b1, 8'h00);
        rst = 1'b1;
        quiet();
        bif.d_icode = IRET;
        cycle("halt_ret_c1", 1'b1, 8'hA0);
        bif.d_icode = INOP; bif.w_halt = 1'b1;
        cycle("halt_ret_c2", 1'b1, 8'hA2);
        bif.w_halt = 1'b0;
        cycle("halted1", 1'b1, 8'hDD);
`ifdef PIPE_CTRL_PERF_EN
        check32("perf_ret_at_halt", perf_ret, 32'd2);
`endif
        for (int i = 0; i < 4; i++) begin
            rand_inputs(1'b0);
            cycle("halted_hold", 1'b1, 8'hDD);
        end
`ifdef PIPE_CTRL_PERF_EN
        check32("perf_ret_frozen", perf_ret, 32'd2);
`endif
        rst = 1'b0;
        #1;
        check8("rst_async", obs_vec(), 8'h00);
        cycle("rst_abort", 1'b1, 8'h00);
        rst = 1'b1;
        quiet();
        cycle("run_after_halt", 1'b1, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            cycle("rand", 1'b0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
